// File: rtl/siso_shift_register.sv
// Serial-in, serial-out delay line: a bit on serial_in leaves serial_out WIDTH edges later.
// Optional macro SISO_PARALLEL_TAP_EN adds parallel_out, a tap of every stage.
module siso_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
`ifdef SISO_PARALLEL_TAP_EN
    output logic [WIDTH-1:0] parallel_out,
`endif
    output logic             serial_out
);

    // Contract: no handshake. One bit is accepted on every rising edge while
    // rst is low, and serial_out always presents the oldest stored bit.

    // shift_reg keeps its name so that it can be probed by hierarchy.
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_reg_d;

    // New bits enter at bit 0 and move toward the MSB. X/Z is passed through unchanged.
    always_comb begin
        shift_reg_d = {shift_reg[WIDTH-2:0], serial_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= shift_reg_d;
        end
    end

    assign serial_out = shift_reg[WIDTH-1];

`ifdef SISO_PARALLEL_TAP_EN
    assign parallel_out = shift_reg;
`endif

endmodule

// File: tb/tb_siso_shift_register.sv
// Directed bench for siso_shift_register: a WIDTH=4 instance and a WIDTH=8 instance.
// Inputs change on falling edges. Outputs are sampled 1 time unit after each rising edge.
module tb_siso_shift_register;

    int errors = 0;
    int checks = 0;

    // Clock and reset drivers.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4 = 1'b0;
    logic in4  = 1'b0;
    logic out4;
    logic rst8 = 1'b0;
    logic in8  = 1'b0;
    logic out8;
`ifdef SISO_PARALLEL_TAP_EN
    logic [3:0] par4;
    logic [7:0] par8;
`endif

    siso_shift_register #(.WIDTH(4)) uut (
        .clk          (clk),
        .rst          (rst4),
        .serial_in    (in4),
`ifdef SISO_PARALLEL_TAP_EN
        .parallel_out (par4),
`endif
        .serial_out   (out4)
    );

    siso_shift_register #(.WIDTH(8)) uut8 (
        .clk          (clk),
        .rst          (rst8),
        .serial_in    (in8),
`ifdef SISO_PARALLEL_TAP_EN
        .parallel_out (par8),
`endif
        .serial_out   (out8)
    );

    // Driver tasks: drive on the falling edge, then return 1 unit after the next rising edge.
    task automatic step4(input logic r, input logic b);
        @(negedge clk);
        rst4 = r;
        in4  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic r, input logic b);
        @(negedge clk);
        rst8 = r;
        in8  = b;
        @(posedge clk);
        #1;
    endtask

    // Checks one edge of the WIDTH=4 instance against hand-computed values.
    task automatic check4(input string name, input logic [3:0] exp_sr, input logic exp_out);
        checks++;
        if (uut.shift_reg !== exp_sr) begin
            errors++;
            $display("FAIL %s shift_reg: got %b want %b", name, uut.shift_reg, exp_sr);
        end
        checks++;
        if (out4 !== exp_out) begin
            errors++;
            $display("FAIL %s serial_out: got %b want %b", name, out4, exp_out);
        end
`ifdef SISO_PARALLEL_TAP_EN
        checks++;
        if (par4 !== exp_sr) begin
            errors++;
            $display("FAIL %s parallel_out: got %b want %b", name, par4, exp_sr);
        end
`endif
    endtask

    task automatic test_reset;
        step4(1'b1, 1'b0);
        check4("reset", 4'b0000, 1'b0);
    endtask

    task automatic test_shift_pattern;
        logic [6:0] bits   = 7'b1011001;
        logic [3:0] exp_sr [7] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011,
                                   4'b0110, 4'b1100, 4'b1001};
        logic [6:0] exp_out = 7'b0001011;
        for (int i = 0; i < 7; i++) begin
            step4(1'b0, bits[6-i]);
            check4($sformatf("shift[%0d]", i), exp_sr[i], exp_out[6-i]);
        end
    endtask

    task automatic test_hold;
        step4(1'b0, 1'b1);
        check4("hold[0]", 4'b0011, 1'b0);
        step4(1'b0, 1'b1);
        check4("hold[1]", 4'b0111, 1'b0);
    endtask

    task automatic test_mid_reset;
        step4(1'b0, 1'b1);
        check4("load_1111", 4'b1111, 1'b1);
        // serial_in is high during reset and must be ignored.
        step4(1'b1, 1'b1);
        check4("mid_reset", 4'b0000, 1'b0);
        step4(1'b1, 1'b1);
        check4("reset_held", 4'b0000, 1'b0);
        step4(1'b0, 1'b1);
        check4("refill[0]", 4'b0001, 1'b0);
        step4(1'b0, 1'b0);
        check4("refill[1]", 4'b0010, 1'b0);
        step4(1'b0, 1'b0);
        check4("refill[2]", 4'b0100, 1'b0);
        step4(1'b0, 1'b0);
        check4("refill[3]", 4'b1000, 1'b1);
        step4(1'b0, 1'b0);
        check4("refill[4]", 4'b0000, 1'b0);
    endtask

    // WIDTH=8: a single 1 is sampled on edge 1 and sits in bit k-1 after edge k.
    task automatic test_width8_pulse;
        logic [7:0] exp_sr;
        logic       exp_out;
        step8(1'b1, 1'b1);
        checks++;
        if (out8 !== 1'b0 || uut8.shift_reg !== 8'h00) begin
            errors++;
            $display("FAIL w8_reset: got sr=%b out=%b want sr=00000000 out=0", uut8.shift_reg, out8);
        end
        for (int k = 1; k <= 10; k++) begin
            step8(1'b0, (k == 1) ? 1'b1 : 1'b0);
            exp_sr  = (k <= 8) ? (8'b1 << (k - 1)) : 8'b0;
            exp_out = (k == 8);
            checks++;
            if (out8 !== exp_out) begin
                errors++;
                $display("FAIL w8_out[%0d]: got %b want %b", k, out8, exp_out);
            end
            checks++;
            if (uut8.shift_reg !== exp_sr) begin
                errors++;
                $display("FAIL w8_sr[%0d]: got %b want %b", k, uut8.shift_reg, exp_sr);
            end
`ifdef SISO_PARALLEL_TAP_EN
            checks++;
            if (par8 !== exp_sr) begin
                errors++;
                $display("FAIL w8_par[%0d]: got %b want %b", k, par8, exp_sr);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_shift_pattern();
        test_hold();
        test_mid_reset();
        test_width8_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/siso_shift_register.md
Name: siso_shift_register

Overview:
- Serial-in, serial-out shift register of parameterisable depth (default 4 stages).
- Delays a 1-bit serial stream by exactly WIDTH clock cycles.
- Used as a fixed-latency bit delay line or serialiser back-end inside the datapath.
- Single clock domain, no handshake; a new bit is accepted on every rising clock edge.

Parameters:
- WIDTH, 4, number of register stages and the latency in cycles from serial_in to serial_out; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; clears all stages.
- serial_in  input  1  serial data bit, sampled on every rising clk edge.
- serial_out  output  1  oldest stored bit, i.e. stage WIDTH-1 of the register.

Behaviour:
- Storage is a single WIDTH-bit register named shift_reg. Verification probes it hierarchically as uut.shift_reg, so the name is mandatory.
- On a rising clk edge with rst=1: shift_reg <= 0. Reset has priority over shifting, and serial_in is ignored that cycle.
- On a rising clk edge with rst=0: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}. The new bit enters at bit 0, and bits move toward the MSB.
- serial_out = shift_reg[WIDTH-1], driven directly from the flop with no combinational path from serial_in.
- Reset value: shift_reg = 0, so serial_out = 0.
- Latency: a bit sampled at edge N appears on serial_out after edge N+WIDTH-1. It is visible for the cycle following that edge, i.e. WIDTH edges from sampling to leaving the register.
- No enable: the register shifts on every non-reset edge. A constant serial_in fills the register with that value after WIDTH edges.
- Reset mid-stream: all in-flight bits are discarded. serial_out is 0 from the reset edge until new data propagates WIDTH edges later.
- rst held for multiple cycles: the register stays 0.
- Before the first reset the contents are X. The bench must reset before checking.
- An X/Z on serial_in propagates through the stages unchanged. No sanitising.

Optional Feature:
- Macro SISO_PARALLEL_TAP_EN.
- When defined: adds an output port parallel_out [WIDTH-1:0] = shift_reg, combinationally driven from the flops and 0 during/after reset. Other behaviour is unchanged.
- When undefined: the port does not exist and the port list is exactly clk, rst, serial_in, serial_out.

Test Plan:
- Setup: clk period 10; serial_in changes on falling edges.
- Reset: rst=1 for one rising edge with serial_in=0 -> shift_reg=4'b0000, serial_out=0.
- Shift pattern: serial_in 1,0,1,1 on four successive edges -> shift_reg 0001, 0010, 0101, 1011. serial_out=1 after the 4th edge (first bit emerges).
- Continue: serial_in 0,0,1 -> shift_reg 0110, 1100, 1001; serial_out 0, 1, 1.
- Hold: serial_in held 1 for 2 more edges -> shift_reg 0011, 0111; serial_out 0, 0.
- Mid-stream reset: after loading 1111, assert rst for one edge -> shift_reg=0000 and serial_out=0 immediately. Then shifting in 1 -> serial_out=1 only after 4 edges.
- Parameter: WIDTH=8, single 1 followed by 0s -> serial_out pulses high for exactly one cycle, 8 edges after sampling. With SISO_PARALLEL_TAP_EN, parallel_out equals shift_reg every cycle.
